demux8_router: RTL and testbench
================================

Name: demux8_router

Overview:
- 1-to-8 demultiplexing router: one 32-bit input stream with a 3-bit destination select fans out to eight output channels.
- Each channel has a one-entry holding register and its own valid/ready handshake.
- Used on the write-back / distribution side of the datapath, where one producer feeds multiple consumers.
- Channel index i corresponds to input i of the 8:1 mux tree (select 3'b000 = channel 0).

Parameters:
WIDTH, 32, data word width per channel
CNT_WIDTH, 16, width of the accepted-word counter

Ports:
clock  input  1  rising-edge clock, the block's only clock
reset  input  1  asynchronous, active-high reset
in_data  input  WIDTH  word to route
in_select  input  3  destination channel index, 0..7
in_valid  input  1  producer has a word
in_ready  output  1  router can accept into channel in_select this cycle
out_data  output  8*WIDTH  channel i data on bits [i*WIDTH +: WIDTH]
out_valid  output  8  channel i holds a word
out_ready  input  8  consumer i takes its word this cycle
accept_count  output  CNT_WIDTH  total words accepted since reset
busy  output  1  OR of out_valid

Behaviour:
- Per-channel state: data_q[i] (WIDTH bits), valid_q[i] (1 bit).
- out_valid[i] = valid_q[i]; out_data slice i = data_q[i]. Both are registered; no combinational input-to-output data path.
- in_ready = ~valid_q[in_select] | out_ready[in_select]. This is combinational and depends only on the selected channel. A combinational path from out_ready to in_ready is permitted.
- accept = in_valid & in_ready. drain[i] = valid_q[i] & out_ready[i].
- Per-channel update each rising clock edge:
  - accept to channel i (sel == i), with or without drain[i]: data_q[i] <= in_data, valid_q[i] <= 1. Simultaneous drain and fill on the same channel gives back-to-back delivery with no bubble.
  - drain[i] only: valid_q[i] <= 0; data_q[i] holds its old value (don't-care when invalid).
  - neither: hold.
- Latency: a word accepted in cycle N appears on out_valid[sel]/out_data at cycle N+1.
- Throughput: one word per cycle into any channel whose consumer keeps out_ready high.
- Non-selected channels are never disturbed by an accept. Drains on all channels proceed in parallel, independent of in_valid.
- Stall: while valid_q[i]=1 and out_ready[i]=0, data_q[i] is held stable and a new word targeting i is not accepted (in_ready=0 for that select).
- Other channels remain reachable while one channel is stalled. No head-of-line blocking beyond the current input word.
- The producer must hold in_data/in_select stable while in_valid=1 and in_ready=0. The router does not latch an unaccepted word.
- accept_count increments by 1 on each accept and wraps from 2^CNT_WIDTH-1 to 0.
- out_ready[i] while valid_q[i]=0 has no effect.
- in_select is always in range: 3 bits address exactly 8 channels.
- Reset (asynchronous, active-high, any time including mid-transfer):
  - valid_q = 8'h00, data_q = 0, accept_count = 0.
  - Therefore out_valid = 0, out_data = 0, busy = 0, in_ready = 1.
  - Pending words are discarded. No out_valid is asserted in the first cycle after reset deassertion.

Test Plan:
- Reset check: assert reset mid-stream with channels 2 and 5 full -> out_valid=8'h00, out_data=0, accept_count=0, in_ready=1 immediately, without waiting for a clock edge.
- Basic routing: send 32'hDEADBEEF sel=3, out_ready=8'hFF -> next cycle out_valid=8'b0000_1000 and slice 3 = DEADBEEF; the cycle after, out_valid=0; accept_count=1.
- Stall and isolation: out_ready[6]=0; send A to ch6 -> in_ready for sel=6 drops to 0. Then send B to ch1 -> accepted, delivered on ch1 while ch6 holds A stable. Raise out_ready[6] -> A drains and in_ready for sel=6 rises in the same cycle.
- Same-channel back-to-back: 8 consecutive words 0..7 to ch0 with out_ready[0]=1 -> out_valid[0] stays high for 8 cycles, data sequence 0..7 with no bubbles, accept_count=8.
- Full sweep: sel 0..7 with data 32'h1000_0000+i, all out_ready=0 -> out_valid=8'hFF and busy=1; then an accept to sel=4 is refused (in_ready=0); release all out_ready -> all eight drain in one cycle.
- Counter wrap: with CNT_WIDTH=4, accept 17 words -> accept_count reads 1.

Source files
------------

// File: rtl/demux8_router.sv
// ---------------------------------------------------------------------------
// demux8_router
//
// Purpose:
//   1-to-8 demultiplexing router. A single input stream carries a word plus
//   a 3-bit destination channel index. Each of the eight output channels has
//   a one-entry holding register and its own valid/ready handshake, so a
//   stalled consumer only blocks words addressed to its own channel.
//
// Handshake (valid/ready, both sides):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. The producer keeps data/select stable while valid is high and ready
//   is low. Once asserted, valid stays high until the transfer completes.
//   Ready may depend combinationally on the other side's ready.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-high reset
//   in_data       word to route
//   in_select     destination channel index 0..7
//   in_valid      producer has a word
//   in_ready      selected channel can take a word this cycle
//   out_data      channel i data on bits [i*WIDTH +: WIDTH] (registered)
//   out_valid     channel i holds a word (registered)
//   out_ready     consumer i takes its word this cycle
//   accept_count  words accepted since reset, wraps at 2^CNT_WIDTH
//   busy          any channel holds a word
// ---------------------------------------------------------------------------
module demux8_router #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [2:0]             in_select,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [8*WIDTH-1:0]     out_data,
    output logic [7:0]             out_valid,
    input  logic [7:0]             out_ready,
    output logic [CNT_WIDTH-1:0]   accept_count,
    output logic                   busy
);

    logic [7:0]           valid_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 accept;

    // A full channel can still take a new word when its consumer drains the
    // old one in the same cycle, which gives back-to-back delivery.
    assign in_ready = ~valid_q[in_select] | out_ready[in_select];
    assign accept   = in_valid & in_ready;

    for (genvar ch = 0; ch < 8; ch++) begin : g_chan
        localparam logic [2:0] CH_IDX = 3'(ch);

        logic [WIDTH-1:0] data_q;
        logic             fill;
        logic             drain;

        assign fill  = accept & (in_select == CH_IDX);
        assign drain = valid_q[ch] & out_ready[ch];

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                data_q      <= '0;
                valid_q[ch] <= 1'b0;
            end else if (fill) begin
                // Fill wins over drain: the drained word leaves and the new
                // one takes its place in the same edge.
                data_q      <= in_data;
                valid_q[ch] <= 1'b1;
            end else if (drain) begin
                // Data is left as-is; it is a don't-care once invalid.
                valid_q[ch] <= 1'b0;
            end
        end

        assign out_data[ch*WIDTH +: WIDTH] = data_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign out_valid    = valid_q;
    assign accept_count = count_q;
    assign busy         = |valid_q;

endmodule

// File: tb/tb_demux8_router.sv
module tb_demux8_router;

    localparam int WIDTH = 32;

    logic              clock;
    logic              reset;
    logic [WIDTH-1:0]  in_data;
    logic [2:0]        in_select;
    logic              in_valid;
    logic              in_ready;
    logic [8*WIDTH-1:0] out_data;
    logic [7:0]        out_valid;
    logic [7:0]        out_ready;
    logic [15:0]       accept_count;
    logic              busy;

    // Narrow-counter instance sharing the same stimulus, for the wrap check.
    logic              s_in_ready;
    logic [8*WIDTH-1:0] s_out_data;
    logic [7:0]        s_out_valid;
    logic [3:0]        s_accept_count;
    logic              s_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    demux8_router #(.WIDTH(WIDTH), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_select(in_select), .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .accept_count(accept_count), .busy(busy)
    );

    demux8_router #(.WIDTH(WIDTH), .CNT_WIDTH(4)) dut_small (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_select(in_select), .in_valid(in_valid),
        .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .accept_count(s_accept_count), .busy(s_busy)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] slice(input int i);
        return out_data[i*WIDTH +: WIDTH];
    endfunction

    task automatic send(input logic [2:0] sel, input logic [WIDTH-1:0] d);
        in_select = sel;
        in_data   = d;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        exp_cnt++;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset     = 1'b0;
        in_data   = '0;
        in_select = 3'd0;
        in_valid  = 1'b0;
        out_ready = 8'h00;

        // Power-on reset, checked before any clock edge.
        #1 reset = 1'b1;
        #1;
        chk("por_out_valid", 256'(out_valid), 256'(8'h00));
        chk("por_out_data",  256'(out_data), 256'd0);
        chk("por_count",     256'(accept_count), 256'd0);
        chk("por_in_ready",  256'(in_ready), 256'd1);
        chk("por_busy",      256'(busy), 256'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_valid", 256'(out_valid), 256'(8'h00));

        // Basic routing.
        out_ready = 8'hFF;
        in_select = 3'd3;
        in_data   = 32'hDEADBEEF;
        in_valid  = 1'b1;
        #1 chk("basic_in_ready", 256'(in_ready), 256'd1);
        tick();
        in_valid = 1'b0;
        exp_cnt++;
        chk("basic_valid", 256'(out_valid), 256'(8'b0000_1000));
        chk("basic_data",  256'(slice(3)), 256'(32'hDEADBEEF));
        chk("basic_busy",  256'(busy), 256'd1);
        chk("basic_count", 256'(accept_count), 256'd1);
        tick();
        chk("basic_drained", 256'(out_valid), 256'(8'h00));

        // Stall on channel 6, isolation of channel 1.
        out_ready = 8'hBF;
        send(3'd6, 32'hAAAA0006);
        chk("stall_valid6", 256'(out_valid), 256'(8'h40));
        chk("stall_data6",  256'(slice(6)), 256'(32'hAAAA0006));
        in_select = 3'd6;
        in_data   = 32'h12345678;
        in_valid  = 1'b1;
        #1 chk("stall_in_ready6", 256'(in_ready), 256'd0);
        in_select = 3'd1;
        in_data   = 32'hBBBB0001;
        #1 chk("stall_in_ready1", 256'(in_ready), 256'd1);
        tick();
        in_valid = 1'b0;
        exp_cnt++;
        chk("iso_valid",  256'(out_valid), 256'(8'h42));
        chk("iso_data1",  256'(slice(1)), 256'(32'hBBBB0001));
        chk("iso_data6",  256'(slice(6)), 256'(32'hAAAA0006));
        tick();
        chk("iso_ch1_gone", 256'(out_valid), 256'(8'h40));
        chk("iso_hold6",    256'(slice(6)), 256'(32'hAAAA0006));
        in_select = 3'd6;
        out_ready = 8'hFF;
        #1 chk("release_in_ready6", 256'(in_ready), 256'd1);
        tick();
        chk("release_drained", 256'(out_valid), 256'(8'h00));
        chk("stall_count", 256'(accept_count), 256'(exp_cnt));

        // Same-channel back-to-back, no bubbles.
        for (int i = 0; i < 8; i++) begin
            in_select = 3'd0;
            in_data   = 32'(i);
            in_valid  = 1'b1;
            tick();
            exp_cnt++;
            chk("b2b_valid", 256'(out_valid), 256'(8'h01));
            chk("b2b_data",  256'(slice(0)), 256'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_end_valid", 256'(out_valid), 256'(8'h00));
        chk("b2b_count", 256'(accept_count), 256'(exp_cnt));

        // Full sweep with all consumers stalled.
        out_ready = 8'h00;
        for (int i = 0; i < 8; i++) send(3'(i), 32'h1000_0000 + 32'(i));
        chk("sweep_valid", 256'(out_valid), 256'(8'hFF));
        chk("sweep_busy",  256'(busy), 256'd1);
        for (int i = 0; i < 8; i++) chk("sweep_data", 256'(slice(i)), 256'(32'h1000_0000 + 32'(i)));
        in_select = 3'd4;
        in_data   = 32'hCAFE0004;
        in_valid  = 1'b1;
        #1 chk("sweep_refuse", 256'(in_ready), 256'd0);
        tick();
        in_valid = 1'b0;
        chk("sweep_keep4", 256'(slice(4)), 256'(32'h1000_0004));
        chk("sweep_count", 256'(accept_count), 256'(exp_cnt));
        out_ready = 8'hFF;
        tick();
        chk("sweep_drain", 256'(out_valid), 256'(8'h00));
        chk("sweep_idle",  256'(busy), 256'd0);

        // Asynchronous reset mid-stream with channels 2 and 5 full.
        out_ready = 8'h00;
        send(3'd2, 32'h2222_2222);
        send(3'd5, 32'h5555_5555);
        chk("pre_reset_valid", 256'(out_valid), 256'(8'h24));
        #2 reset = 1'b1;
        #1;
        chk("ar_out_valid", 256'(out_valid), 256'(8'h00));
        chk("ar_out_data",  256'(out_data), 256'd0);
        chk("ar_count",     256'(accept_count), 256'd0);
        chk("ar_in_ready",  256'(in_ready), 256'd1);
        chk("ar_busy",      256'(busy), 256'd0);
        exp_cnt = 0;
        tick();
        reset = 1'b0;
        tick();
        chk("ar_after_valid", 256'(out_valid), 256'(8'h00));

        // Counter wrap on the 4-bit instance.
        out_ready = 8'hFF;
        for (int i = 0; i < 17; i++) send(3'(i % 8), 32'h7000_0000 + 32'(i));
        chk("wrap_count16", 256'(accept_count), 256'd17);
        chk("wrap_count4",  256'(s_accept_count), 256'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
